// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: control bundle, data/register widths, FSM states.
// Also holds the address legality check used by the stage.
package mem_access_stage_pkg;

    localparam int ADDR_W = 10;

    typedef logic [31:0] DATA;
    typedef logic [4:0]  reg_width;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic halt;
    } MemCtrl;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } stage_state_t;

    // A byte address is illegal if it is not word aligned or lies beyond the array.
    function automatic logic bad_addr(input DATA addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/mem_access_stage_data_mem.sv
// Word-addressed data memory: synchronous write, combinational read.
// Contents are deliberately not reset.
module data_mem_array
    import mem_access_stage_pkg::*;
#(
    parameter int MEM_WORDS = 1 << ADDR_W,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] index,
    input  DATA           wdata,
    output DATA           rdata
);

    DATA mem [MEM_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM capture, multi-cycle data memory access with upstream
// stall, registered MEM/WB bundle and a one-cycle taken-branch redirect.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int MEM_WORDS = 1 << ADDR_W,
    parameter int MEM_LAT   = 2
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     ex_valid,
    input  MemCtrl   ex_ctrl,
    input  DATA      alu_o,
    input  DATA      wr_data,
    input  reg_width exec_read,
    input  logic     is_taken,
    input  DATA      addr_new,
    output logic     stall,
    output logic     redirect_valid,
    output DATA      redirect_addr,
    output logic     wb_valid,
    output logic     wb_reg_write,
    output reg_width wb_dest,
    output DATA      wb_data,
    output logic     mem_fault,
    output logic     halted
);

    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    stage_state_t state;
    logic [3:0]   cnt;

    // EX/MEM register, only consulted while an access is in flight
    logic     q_read;
    logic     q_write;
    logic     q_rw;
    DATA      q_alu;
    DATA      q_wdata;
    reg_width q_dest;

    logic          accept;
    logic          in_is_mem;
    logic          fast_access;
    logic          do_access;
    logic          a_read;
    logic          a_write;
    logic          a_rw;
    DATA           a_alu;
    DATA           a_wdata;
    reg_width      a_dest;
    logic          a_fault;
    logic [AW-1:0] a_index;
    logic          mem_we;
    DATA           rdata;

    assign stall     = (state == ST_BUSY);
    assign accept    = ex_valid && !stall && !halted;
    assign in_is_mem = ex_ctrl.mem_read || ex_ctrl.mem_write;

    // Single-cycle memory completes straight from the EX inputs; otherwise from the latch.
    assign fast_access = (MEM_LAT == 1) && accept && in_is_mem && !ex_ctrl.halt;
    assign do_access   = fast_access || (stall && (cnt == 4'd1));

    assign a_read  = stall ? q_read  : ex_ctrl.mem_read;
    assign a_write = stall ? q_write : ex_ctrl.mem_write;
    assign a_rw    = stall ? q_rw    : ex_ctrl.reg_write;
    assign a_alu   = stall ? q_alu   : alu_o;
    assign a_wdata = stall ? q_wdata : wr_data;
    assign a_dest  = stall ? q_dest  : exec_read;

    assign a_fault = bad_addr(a_alu, AW);
    assign a_index = a_alu[AW+1:2];
    // Read wins over write; reset gates the write so an abandoned store never lands.
    assign mem_we  = do_access && !reset && a_write && !a_read && !a_fault;

    data_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .index (a_index),
        .wdata (a_wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            q_read         <= 1'b0;
            q_write        <= 1'b0;
            q_rw           <= 1'b0;
            q_alu          <= '0;
            q_wdata        <= '0;
            q_dest         <= '0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_dest        <= '0;
            wb_data        <= '0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
            mem_fault      <= 1'b0;
            halted         <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            redirect_valid <= 1'b0;

            if (do_access) begin
                wb_valid     <= 1'b1;
                wb_dest      <= a_dest;
                wb_reg_write <= a_read && a_rw && !a_fault;
                wb_data      <= (a_read && !a_fault) ? rdata : a_alu;
                if (a_fault) begin
                    mem_fault <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (ex_ctrl.halt) begin
                            halted <= 1'b1;
                        end else begin
                            redirect_valid <= is_taken;
                            if (is_taken) begin
                                redirect_addr <= addr_new;
                            end
                            if (in_is_mem) begin
                                q_read  <= ex_ctrl.mem_read;
                                q_write <= ex_ctrl.mem_write;
                                q_rw    <= ex_ctrl.reg_write;
                                q_alu   <= alu_o;
                                q_wdata <= wr_data;
                                q_dest  <= exec_read;
                                if (MEM_LAT > 1) begin
                                    state <= ST_BUSY;
                                    cnt   <= CNT_INIT;
                                end
                            end else begin
                                wb_valid     <= 1'b1;
                                wb_dest      <= exec_read;
                                wb_reg_write <= ex_ctrl.reg_write;
                                wb_data      <= alu_o;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with MEM_LAT = 3: a vector table of single
// transactions plus hand sequences for faults, reset during BUSY and halt.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int LAT   = 3;
    localparam int WORDS = 1024;

    logic     clock = 1'b0;
    logic     reset;
    logic     ex_valid;
    MemCtrl   ex_ctrl;
    DATA      alu_o;
    DATA      wr_data;
    reg_width exec_read;
    logic     is_taken;
    DATA      addr_new;
    logic     stall;
    logic     redirect_valid;
    DATA      redirect_addr;
    logic     wb_valid;
    logic     wb_reg_write;
    reg_width wb_dest;
    DATA      wb_data;
    logic     mem_fault;
    logic     halted;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(
        .MEM_WORDS (WORDS),
        .MEM_LAT   (LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_ctrl        (ex_ctrl),
        .alu_o          (alu_o),
        .wr_data        (wr_data),
        .exec_read      (exec_read),
        .is_taken       (is_taken),
        .addr_new       (addr_new),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_dest        (wb_dest),
        .wb_data        (wb_data),
        .mem_fault      (mem_fault),
        .halted         (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic     rd;
        logic     wr;
        logic     rw;
        DATA      alu;
        DATA      wdat;
        reg_width dest;
        logic     taken;
        DATA      target;
        logic     exp_rw;
        reg_width exp_dest;
        logic     chk_data;
        DATA      exp_data;
        logic     exp_redir;
        int       exp_stall;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic rd, input logic wr, input logic rw,
                                input DATA alu, input DATA wdat, input reg_width dest,
                                input logic taken, input DATA target,
                                input logic exp_rw, input reg_width exp_dest,
                                input logic chk_data, input DATA exp_data,
                                input logic exp_redir, input int exp_stall);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rw = rw; v.alu = alu; v.wdat = wdat; v.dest = dest;
        v.taken = taken; v.target = target; v.exp_rw = exp_rw; v.exp_dest = exp_dest;
        v.chk_data = chk_data; v.exp_data = exp_data; v.exp_redir = exp_redir;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one bundle for exactly one accepting edge; returns #1 after that edge.
    task automatic send(input logic rd, input logic wr, input logic rw, input logic hlt,
                        input DATA alu, input DATA wdat, input reg_width dest,
                        input logic taken, input DATA target);
        @(negedge clock);
        ex_valid  = 1'b1;
        ex_ctrl   = '{mem_read: rd, mem_write: wr, reg_write: rw, halt: hlt};
        alu_o     = alu;
        wr_data   = wdat;
        exec_read = dest;
        is_taken  = taken;
        addr_new  = target;
        @(posedge clock);
        #1;
        ex_valid  = 1'b0;
        is_taken  = 1'b0;
    endtask

    task automatic wait_wb(output int stalls, output logic found);
        stalls = 0;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (wb_valid) begin
                found = 1'b1;
                break;
            end
            if (stall) stalls++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   stalls;
        logic found;
        send(v.rd, v.wr, v.rw, 1'b0, v.alu, v.wdat, v.dest, v.taken, v.target);
        chk({tag, "_redirect"}, 32'(redirect_valid), 32'(v.exp_redir));
        if (v.exp_redir) chk({tag, "_raddr"}, redirect_addr, v.target);
        wait_wb(stalls, found);
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s_timeout wb_valid never rose within 8 cycles", tag);
        end else begin
            chk({tag, "_stalls"}, 32'(stalls), 32'(v.exp_stall));
            chk({tag, "_rw"}, 32'(wb_reg_write), 32'(v.exp_rw));
            chk({tag, "_dest"}, 32'(wb_dest), 32'(v.exp_dest));
            if (v.chk_data) chk({tag, "_data"}, wb_data, v.exp_data);
        end
        @(posedge clock);
        #1;
        chk({tag, "_wb_pulse"}, 32'(wb_valid), 32'd0);
        chk({tag, "_redir_pulse"}, 32'(redirect_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        ex_valid  = 1'b0;
        ex_ctrl   = '0;
        alu_o     = '0;
        wr_data   = '0;
        exec_read = '0;
        is_taken  = 1'b0;
        addr_new  = '0;

        //                rd wr rw alu            wdat           dst tk target         erw edst cd edata          erd st
        vecs[0]  = mk(0, 0, 1, 32'h0000_0007, 32'h0,         5,  0, 32'h0,         1,  5,  1, 32'h0000_0007, 0, 0);
        vecs[1]  = mk(0, 0, 0, 32'h0000_0011, 32'h0,         0,  1, 32'h0000_0100, 0,  0,  1, 32'h0000_0011, 1, 0);
        vecs[2]  = mk(0, 1, 0, 32'h0000_0040, 32'hDEAD_BEEF, 0,  0, 32'h0,         0,  0,  0, 32'h0,         0, 2);
        vecs[3]  = mk(1, 0, 1, 32'h0000_0040, 32'h0,         9,  0, 32'h0,         1,  9,  1, 32'hDEAD_BEEF, 0, 2);
        vecs[4]  = mk(0, 1, 0, 32'h0000_0080, 32'h1234_5678, 0,  0, 32'h0,         0,  0,  0, 32'h0,         0, 2);
        vecs[5]  = mk(0, 1, 0, 32'h0000_0000, 32'hA5A5_A5A5, 0,  0, 32'h0,         0,  0,  0, 32'h0,         0, 2);
        vecs[6]  = mk(0, 1, 0, 32'h0000_0FFC, 32'h0F0F_0F0F, 0,  0, 32'h0,         0,  0,  0, 32'h0,         0, 2);
        vecs[7]  = mk(1, 1, 1, 32'h0000_0040, 32'h0000_0BAD, 6,  0, 32'h0,         1,  6,  1, 32'hDEAD_BEEF, 0, 2);
        vecs[8]  = mk(1, 0, 1, 32'h0000_0040, 32'h0,         10, 0, 32'h0,         1,  10, 1, 32'hDEAD_BEEF, 0, 2);
        vecs[9]  = mk(1, 0, 1, 32'h0000_0FFC, 32'h0,         11, 0, 32'h0,         1,  11, 1, 32'h0F0F_0F0F, 0, 2);
        vecs[10] = mk(1, 0, 0, 32'h0000_0080, 32'h0,         12, 0, 32'h0,         0,  12, 1, 32'h1234_5678, 0, 2);
        vecs[11] = mk(0, 0, 1, 32'hFFFF_FFFF, 32'h0,         31, 1, 32'hFFFF_FFFC, 1,  31, 1, 32'hFFFF_FFFF, 1, 0);

        // Reset state
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_raddr", redirect_addr, 32'd0);
        chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_dest", 32'(wb_dest), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end
        chk("no_fault_yet", 32'(mem_fault), 32'd0);

        // Misaligned load: fault, no register write, same latency
        run_vec(mk(1, 0, 1, 32'h0000_0042, 32'h0, 4, 0, 32'h0, 0, 4, 0, 32'h0, 0, 2), "f_misload");
        chk("f_sticky0", 32'(mem_fault), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        chk("f_sticky1", 32'(mem_fault), 32'd1);
        // Misaligned store must not corrupt the aligned word it would alias
        run_vec(mk(0, 1, 0, 32'h0000_0042, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 2), "f_misstore");
        run_vec(mk(1, 0, 1, 32'h0000_0040, 32'h0, 8, 0, 32'h0, 1, 8, 1, 32'hDEAD_BEEF, 0, 2), "f_chk40");
        // Out-of-range store at 4*MEM_WORDS must not wrap onto word 0
        run_vec(mk(0, 1, 0, 32'h0000_1000, 32'h0000_0055, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 2), "f_oorstore");
        run_vec(mk(1, 0, 1, 32'h0000_0000, 32'h0, 1, 0, 32'h0, 1, 1, 1, 32'hA5A5_A5A5, 0, 2), "f_chk00");
        run_vec(mk(1, 0, 1, 32'h0000_1000, 32'h0, 7, 0, 32'h0, 0, 7, 0, 32'h0, 0, 2), "f_oorload");
        chk("f_sticky2", 32'(mem_fault), 32'd1);

        // Reset during BUSY of a store to 0x80
        send(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0);
        chk("rb_busy", 32'(stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rb_stall", 32'(stall), 32'd0);
        chk("rb_wb_valid", 32'(wb_valid), 32'd0);
        chk("rb_fault", 32'(mem_fault), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_vec(mk(1, 0, 1, 32'h0000_0080, 32'h0, 3, 0, 32'h0, 1, 3, 1, 32'h1234_5678, 0, 2), "rb_load80");

        // Halt, then ALU ops that must be ignored
        send(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0099, 32'h0, 5'd2, 1'b0, 32'h0);
        chk("h_halted", 32'(halted), 32'd1);
        chk("h_wb_valid", 32'(wb_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0, 1'b1, 1'b0, 32'(i + 1), 32'h0, 5'd3, 1'b1, 32'h0000_0200);
            chk($sformatf("h_ign%0d_wb", i), 32'(wb_valid), 32'd0);
            chk($sformatf("h_ign%0d_redir", i), 32'(redirect_valid), 32'd0);
            @(posedge clock);
            #1;
            chk($sformatf("h_ign%0d_wb2", i), 32'(wb_valid), 32'd0);
            chk($sformatf("h_ign%0d_halted", i), 32'(halted), 32'd1);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("h_rst_halted", 32'(halted), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_vec(mk(0, 0, 1, 32'h0000_0123, 32'h0, 14, 0, 32'h0, 1, 14, 1, 32'h0000_0123, 0, 0), "h_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
